// File: rtl/mips_mem_pkg.sv
// Shared memory-side types for the MIPS datapath: store buffer sizing and entry layout.
package mips_mem_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic                 valid;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Datapath-side and memory-side signals of the store buffer in one bundle.
interface store_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              stall;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              empty;
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_Data;
  logic [DATA_W-1:0] mem_read_Data;

  // master: datapath plus data memory, i.e. everything around the buffer
  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_Data,
    input  st_ready, stall, ld_data, empty, memRead, memWrite, mem_address, mem_write_Data
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_Data,
    output st_ready, stall, ld_data, empty, memRead, memWrite, mem_address, mem_write_Data
  );
endinterface

// File: rtl/store_buffer_fwd.sv
// Youngest-match search over pending stores for load forwarding.
module store_buffer_fwd
  import mips_mem_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t              entries [DEPTH],
  input  logic [PTR_W-1:0]       head,
  input  logic [SB_ADDR_W-1:0]   ld_addr,
  output logic                   hit,
  output logic [SB_DATA_W-1:0]   data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest; a later match overwrites, leaving the youngest.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (entries[idx].valid && (entries[idx].addr == ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between datapath and single-port data memory, with load forwarding.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter  int DEPTH  = SB_DEPTH,
  parameter  int ADDR_W = SB_ADDR_W,
  parameter  int DATA_W = SB_DATA_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave sb
);

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic              full;
  logic              is_empty;
  logic              enq;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              ld_hit;
  logic              ld_miss;

  store_buffer_fwd #(.DEPTH(DEPTH)) u_fwd (
    .entries (entries),
    .head    (head),
    .ld_addr (sb.ld_addr),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  assign full     = (count == CNT_W'(DEPTH));
  assign is_empty = (count == '0);
  assign ld_hit   = sb.ld_valid & fwd_hit;
  assign ld_miss  = sb.ld_valid & ~fwd_hit;

  // Full is sampled from registered count only, so a same-cycle drain cannot admit a store.
  assign enq   = sb.st_valid & ~full;
  assign drain = ~reset & ~ld_miss & ~is_empty;

  assign sb.st_ready = ~full;
  assign sb.stall    = sb.st_valid & full;
  assign sb.empty    = is_empty;

  always_comb begin
    sb.memRead        = 1'b0;
    sb.memWrite       = 1'b0;
    sb.mem_address    = {ADDR_W{1'b0}};
    sb.mem_write_Data = {DATA_W{1'b0}};
    if (ld_miss) begin
      sb.memRead     = 1'b1;
      sb.mem_address = sb.ld_addr;
    end else if (drain) begin
      sb.memWrite       = 1'b1;
      sb.mem_address    = entries[head].addr;
      sb.mem_write_Data = entries[head].data;
    end
  end

  always_comb begin
    sb.ld_data = {DATA_W{1'b0}};
    if (ld_hit)
      sb.ld_data = fwd_data;
    else if (ld_miss)
      sb.ld_data = sb.mem_read_Data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        entries[i] <= '0;
    end else begin
      // enq and drain never touch the same slot: enq needs !full, drain needs !empty
      if (enq) begin
        entries[tail] <= '{addr: sb.st_addr, data: sb.st_data, valid: 1'b1};
        tail          <= tail + PTR_W'(1);
      end
      if (drain) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(drain);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: queue-based reference model checked every cycle plus literal checks.
module tb_store_buffer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic chk_en;

  store_buffer_if #(.ADDR_W(32), .DATA_W(32)) sbi ();

  store_buffer dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbi)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  ent_t wr_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending stores as a queue, youngest at the back.
  always @(negedge clk) begin
    logic        m_full, m_empty, hit, miss, drn;
    logic [31:0] fd, e_addr, e_wdata, e_ld;
    ent_t        e;
    if (sbi.memWrite === 1'b1) begin
      e.a = sbi.mem_address;
      e.d = sbi.mem_write_Data;
      wr_log.push_back(e);
    end
    if (chk_en) begin
      m_full  = (mq.size() == 4);
      m_empty = (mq.size() == 0);
      hit = 1'b0;
      fd  = '0;
      foreach (mq[i]) if (mq[i].a == sbi.ld_addr) begin hit = 1'b1; fd = mq[i].d; end
      miss = sbi.ld_valid && !hit;
      drn  = !reset && !miss && !m_empty;
      e_addr  = miss ? sbi.ld_addr : (drn ? mq[0].a : 32'h0);
      e_wdata = (drn && !miss) ? mq[0].d : 32'h0;
      e_ld    = !sbi.ld_valid ? 32'h0 : (hit ? fd : sbi.mem_read_Data);
      check("st_ready", {31'b0, sbi.st_ready}, {31'b0, !m_full});
      check("stall", {31'b0, sbi.stall}, {31'b0, sbi.st_valid && m_full});
      check("empty", {31'b0, sbi.empty}, {31'b0, m_empty});
      check("memRead", {31'b0, sbi.memRead}, {31'b0, miss});
      check("memWrite", {31'b0, sbi.memWrite}, {31'b0, drn});
      check("mem_address", sbi.mem_address, e_addr);
      check("mem_write_Data", sbi.mem_write_Data, e_wdata);
      check("ld_data", sbi.ld_data, e_ld);
      if (reset) mq.delete();
      else begin
        if (drn) void'(mq.pop_front());
        if (sbi.st_valid && !m_full) begin
          e.a = sbi.st_addr;
          e.d = sbi.st_data;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    sbi.st_valid = 1'b1;
    sbi.st_addr  = a;
    sbi.st_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; chk_en = 1'b0;
    reset = 1'b1;
    sbi.st_valid = 0; sbi.st_addr = 0; sbi.st_data = 0;
    sbi.ld_valid = 0; sbi.ld_addr = 0; sbi.mem_read_Data = 32'hDEAD_0000;
    step(); step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst st_ready", {31'b0, sbi.st_ready}, 32'h1);
    check("rst empty", {31'b0, sbi.empty}, 32'h1);
    check("rst memWrite", {31'b0, sbi.memWrite}, 32'h0);
    check("rst memRead", {31'b0, sbi.memRead}, 32'h0);
    check("rst mem_address", sbi.mem_address, 32'h0);
    check("rst ld_data", sbi.ld_data, 32'h0);

    // single store drains the following cycle
    step(); store(5, 32'h1234);
    step(); sbi.st_valid = 0; #1;
    check("t1 memWrite", {31'b0, sbi.memWrite}, 32'h1);
    check("t1 mem_address", sbi.mem_address, 32'd5);
    check("t1 mem_write_Data", sbi.mem_write_Data, 32'h1234);
    step(); #1;
    check("t1 empty after", {31'b0, sbi.empty}, 32'h1);

    // two stores to one address, load forwards the younger
    step(); wr_log.delete();
    store(3, 32'hA); sbi.ld_valid = 1; sbi.ld_addr = 99;
    step(); store(3, 32'hB);
    step(); sbi.st_valid = 0; sbi.ld_addr = 3; #1;
    check("t2 ld_data", sbi.ld_data, 32'hB);
    check("t2 memRead", {31'b0, sbi.memRead}, 32'h0);
    step(); sbi.ld_valid = 0;
    step(); step();
    check("t2 log size", wr_log.size(), 32'd2);
    if (wr_log.size() == 2) begin
      check("t2 first write", wr_log[0].d, 32'hA);
      check("t2 second write", wr_log[1].d, 32'hB);
    end

    // fill while a load miss blocks the drain
    wr_log.delete();
    sbi.ld_valid = 1; sbi.ld_addr = 40; sbi.mem_read_Data = 32'h4040;
    for (int i = 0; i < 4; i++) begin
      store(10 + i, 32'h100 + i);
      step();
    end
    store(14, 32'h104); #1;
    check("t3 st_ready full", {31'b0, sbi.st_ready}, 32'h0);
    check("t3 stall", {31'b0, sbi.stall}, 32'h1);
    check("t3 miss ld_data", sbi.ld_data, 32'h4040);
    step(); sbi.ld_valid = 0; #1;
    check("t3 stall during drain", {31'b0, sbi.stall}, 32'h1);
    check("t3 first drain addr", sbi.mem_address, 32'd10);
    step(); #1;
    check("t3 fifth accepted", {31'b0, sbi.stall}, 32'h0);
    check("t3 second drain addr", sbi.mem_address, 32'd11);
    step(); sbi.st_valid = 0;
    repeat (5) step();
    check("t3 log size", wr_log.size(), 32'd5);
    foreach (wr_log[i]) begin
      check("t3 order addr", wr_log[i].a, 32'd10 + i);
      check("t3 order data", wr_log[i].d, 32'h100 + i);
    end

    // load miss with stores pending leaves head in place
    wr_log.delete();
    sbi.mem_read_Data = 32'd87; sbi.ld_valid = 1; sbi.ld_addr = 7;
    store(20, 32'h20);
    step(); store(21, 32'h21);
    step(); sbi.st_valid = 0; #1;
    check("t4 memRead", {31'b0, sbi.memRead}, 32'h1);
    check("t4 mem_address", sbi.mem_address, 32'd7);
    check("t4 ld_data", sbi.ld_data, 32'd87);
    check("t4 memWrite", {31'b0, sbi.memWrite}, 32'h0);
    step(); sbi.ld_valid = 0; #1;
    check("t4 head drain addr", sbi.mem_address, 32'd20);
    check("t4 head drain data", sbi.mem_write_Data, 32'h20);
    repeat (3) step();

    // reset with pending stores discards them
    wr_log.delete();
    sbi.ld_valid = 1; sbi.ld_addr = 7;
    for (int i = 0; i < 3; i++) begin
      store(30 + i, 32'h300 + i);
      step();
    end
    sbi.st_valid = 0; sbi.ld_valid = 0; reset = 1; #1;
    check("t5 memWrite in reset", {31'b0, sbi.memWrite}, 32'h0);
    step(); reset = 0; #1;
    check("t5 empty", {31'b0, sbi.empty}, 32'h1);
    check("t5 st_ready", {31'b0, sbi.st_ready}, 32'h1);
    check("t5 memWrite", {31'b0, sbi.memWrite}, 32'h0);
    repeat (3) step();
    check("t5 no writes", wr_log.size(), 32'd0);

    // streaming store/drain pairs wrap the pointers
    wr_log.delete();
    for (int i = 0; i < 10; i++) begin
      store(50 + i, 32'h500 + i);
      step();
    end
    sbi.st_valid = 0;
    repeat (3) step();
    check("t6 log size", wr_log.size(), 32'd10);
    foreach (wr_log[i]) begin
      check("t6 order addr", wr_log[i].a, 32'd50 + i);
      check("t6 order data", wr_log[i].d, 32'h500 + i);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
